rand_delay_ctrl: RTL

Random-latency handshake controller that consumes the pseudo-random word produced by the LFSR stage. On each accepted request it samples the LFSR output, converts it into a bounded delay, waits that many cycles, and then issues a response. It also pulses the LFSR enable exactly once per accepted request. It sits between a bus/memory stub and the LFSR to inject randomized response latency for NPC bus testing.

---
 rtl/rand_delay_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/rand_delay_ctrl.sv
// rand_delay_ctrl: random-latency request/response handshake controller.
// Each accepted request samples a delay (from the LFSR word or a fixed
// configuration value). The controller waits that many cycles, then presents
// a response and holds it until the response handshake completes. The LFSR
// is advanced once per accepted request.
module rand_delay_ctrl #(
    parameter int W  = 5,
    parameter int DW = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  rnd,
    output logic          rnd_en,
    input  logic          req_valid,
    output logic          req_ready,
    output logic          resp_valid,
    input  logic          resp_ready,
    input  logic          cfg_fixed,
    input  logic [DW-1:0] cfg_dly,
    output logic          busy,
    output logic [CW-1:0] txn_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] cnt;
    logic [DW-1:0] dly;
    logic          accept;
    logic          resp_done;

    // Only the low DW bits of the LFSR word select the delay.
    logic unused_rnd;
    assign unused_rnd = ^rnd;

    assign dly       = cfg_fixed ? cfg_dly : rnd[DW-1:0];
    assign accept    = req_valid && (state == S_IDLE);
    assign resp_done = (state == S_RESP) && resp_ready;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    // Kept low during reset so the LFSR does not advance on an aborted cycle.
    assign rnd_en     = req_valid && (state == S_IDLE) && !rst;

    // State register; reset aborts any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a zero delay skips the WAIT state entirely.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (dly == '0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == DW'(1)) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Delay down-counter: loaded on acceptance, decremented while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= dly;
        end else if (state == S_WAIT) begin
            cnt <= cnt - DW'(1);
        end
    end

    // Completed-transaction counter, wraps naturally at 2^CW.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt <= '0;
        end else if (resp_done) begin
            txn_cnt <= txn_cnt + CW'(1);
        end
    end

endmodule
